apb_arbiter: RTL and testbench
==============================

Name: apb_arbiter

Overview:
- Two-requester APB arbiter sharing one APB slave bus between the CPU core (port m0) and a second bus master such as DMA or debug (port m1).
- Captures a granted request, re-issues it on the shared bus as a clean SETUP/ACCESS sequence, and routes the response back to the owner.
- Stalls the non-granted requester by holding its pready low.
- Sits between the core's APB master pins and the peripheral/memory interconnect.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, data width on all ports; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic on posedge.
- rts_n  input  1  synchronous active-low reset.
- mN_psel  input  1  requester N select (N = 0, 1; identical sets for m0 and m1).
- mN_penable  input  1  requester N enable phase; ignored for arbitration.
- mN_pwrite  input  1  requester N write.
- mN_paddr  input  ADDR_WIDTH  requester N address.
- mN_pdata  input  DATA_WIDTH  requester N write data.
- mN_pstb  input  DATA_WIDTH/8  requester N byte strobes.
- mN_prdata  output  DATA_WIDTH  read data returned to N.
- mN_pready  output  1  transfer-complete strobe to N.
- mN_perr  output  1  error returned to N; valid with mN_pready.
- s_psel  output  1  shared bus select.
- s_penable  output  1  shared bus enable.
- s_pwrite  output  1  shared bus write.
- s_paddr  output  ADDR_WIDTH  shared bus address.
- s_pdata  output  DATA_WIDTH  shared bus write data.
- s_pstb  output  DATA_WIDTH/8  shared bus strobes.
- s_prdata  input  DATA_WIDTH  slave read data.
- s_pready  input  1  slave ready.
- s_perr  input  1  slave error.
- gnt  output  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (rts_n low at a posedge): state=IDLE, gnt=00, s_psel=s_penable=s_pwrite=0, s_paddr=s_pdata=0, s_pstb=0, last=1 (m0 wins the first tie). All mN_pready=0, mN_perr=0. Reset mid-transfer abandons the transfer immediately with no completion strobe.
- State machine: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - Request N is pending when mN_psel=1.
  - If both are pending, grant the port != last; else grant the single pending port.
  - On grant, register pwrite/paddr/pdata/pstb from the winner, set gnt, go to SETUP.
- SETUP: s_psel=1, s_penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - s_psel=1, s_penable=1.
  - Wait for s_pready. In that same cycle, combinationally drive m<gnt>_pready=1, m<gnt>_prdata=s_prdata, m<gnt>_perr=s_perr.
  - Next cycle: IDLE, last=granted port, gnt=00, s_psel=s_penable=0.
- Minimum latency: mN_psel sampled in cycle N; s_psel in N+1; s_penable in N+2; mN_pready no earlier than N+2.
- Back-to-back: at least one IDLE cycle between transfers. This gives the requester one cycle to drop or change psel after pready, so a stale psel is never re-granted.
- Non-owner: mN_pready=0 and mN_prdata=0 throughout. Its psel may stay high indefinitely; it is served after the current transfer completes.
- Requesters must hold their signals stable from psel rise until their pready. Changes after the grant cycle are ignored because the shared bus uses the registered copies.
- A requester dropping psel after grant does not abort the transfer; it completes on the bus and the response is discarded.
- s_pwrite and s_pstb come from the registered copy; s_pstb is forced to all-ones on reads.
- Round-robin fairness: with both requesters continuously asserting psel, grants strictly alternate.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on ACCESS entry and increments each ACCESS cycle without s_pready.
  - When it reaches TIMEOUT_CYCLES, the owner gets mN_pready=1, mN_perr=1, mN_prdata=0.
  - s_psel/s_penable deassert next cycle and the FSM returns to IDLE.
  - A late s_pready is ignored.
- Not defined: no counter; ACCESS waits on s_pready indefinitely.

Decomposition:
- Package apb_arb_pkg: state encoding constants (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_ACCESS=2'd2), NUM_REQ=2, port index constants M_CPU=0, M_AUX=1.
- One sub-module, rr_pick2: combinational two-way round-robin selector. Inputs are the req vector and last; output is the one-hot grant.
- FSM, capture registers and response routing stay in apb_arbiter.

Test Plan:
- m0 read at 0x1000, slave pready after 2 ACCESS wait cycles with prdata=0xDEADBEEF -> s_psel in N+1, s_penable in N+2, m0_pready=1 with m0_prdata=0xDEADBEEF in N+4, m1_pready=0 throughout.
- m0 and m1 assert psel in the same cycle after reset -> m0 is granted first; m1 is granted on the IDLE cycle after m0 completes; gnt goes 01 -> 00 -> 10.
- Both hold psel continuously for 6 transfers -> gnt order 01,10,01,10,01,10.
- m1 write paddr=0x4, pdata=0x55, pstb=0001 while m1 changes paddr to 0x8 during ACCESS -> s_paddr stays 0x4, s_pstb=0001, s_pwrite=1.
- Slave returns s_perr=1 with pready -> owner sees perr=1 for that one cycle only; with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4 and pready never asserted -> owner gets pready=1, perr=1 after 4 ACCESS cycles.
- rts_n low during ACCESS -> next cycle s_psel=s_penable=0, gnt=00, no mN_pready pulse; first request after reset is served normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared encodings for the two-requester APB arbiter: FSM states and requester indices.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   localparam int NUM_REQ = 2;
   localparam int M_CPU   = 0;
   localparam int M_AUX   = 1;

endpackage

// File: rtl/apb_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the port that did not win last time is chosen.
module rr_pick2
   import apb_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last,
   output logic [NUM_REQ-1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req[M_CPU] && req[M_AUX]) begin
         gnt[M_CPU] = last;
         gnt[M_AUX] = ~last;
      end
   end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter: captures the winning request and replays it as SETUP/ACCESS.
// Optional ACCESS-phase watchdog is enabled by defining ARB_TIMEOUT_EN.
module apb_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic                    clk,
   input  logic                    rts_n,
   input  logic                    m0_psel,
   input  logic                    m0_penable,
   input  logic                    m0_pwrite,
   input  logic [ADDR_WIDTH-1:0]   m0_paddr,
   input  logic [DATA_WIDTH-1:0]   m0_pdata,
   input  logic [DATA_WIDTH/8-1:0] m0_pstb,
   output logic [DATA_WIDTH-1:0]   m0_prdata,
   output logic                    m0_pready,
   output logic                    m0_perr,
   input  logic                    m1_psel,
   input  logic                    m1_penable,
   input  logic                    m1_pwrite,
   input  logic [ADDR_WIDTH-1:0]   m1_paddr,
   input  logic [DATA_WIDTH-1:0]   m1_pdata,
   input  logic [DATA_WIDTH/8-1:0] m1_pstb,
   output logic [DATA_WIDTH-1:0]   m1_prdata,
   output logic                    m1_pready,
   output logic                    m1_perr,
   output logic                    s_psel,
   output logic                    s_penable,
   output logic                    s_pwrite,
   output logic [ADDR_WIDTH-1:0]   s_paddr,
   output logic [DATA_WIDTH-1:0]   s_pdata,
   output logic [DATA_WIDTH/8-1:0] s_pstb,
   input  logic [DATA_WIDTH-1:0]   s_prdata,
   input  logic                    s_pready,
   input  logic                    s_perr,
   output logic [NUM_REQ-1:0]      gnt
);

   localparam int STB_WIDTH = DATA_WIDTH / 8;

   state_t                  state_reg;
   logic [NUM_REQ-1:0]      gnt_reg;
   logic                    last_reg;
   logic                    psel_reg;
   logic                    penable_reg;
   logic                    pwrite_reg;
   logic [ADDR_WIDTH-1:0]   paddr_reg;
   logic [DATA_WIDTH-1:0]   pdata_reg;
   logic [STB_WIDTH-1:0]    pstb_reg;

   logic [NUM_REQ-1:0]      pick;
   logic                    win_pwrite;
   logic [ADDR_WIDTH-1:0]   win_paddr;
   logic [DATA_WIDTH-1:0]   win_pdata;
   logic [STB_WIDTH-1:0]    win_pstb;
   logic                    timeout;
   logic                    done;
   logic                    complete;
   logic                    unused_in;

   logic                    rsp_ready [NUM_REQ];
   logic                    rsp_err   [NUM_REQ];
   logic [DATA_WIDTH-1:0]   rsp_data  [NUM_REQ];

   assign unused_in = m0_penable ^ m1_penable;

   rr_pick2 u_pick (
      .req  ({m1_psel, m0_psel}),
      .last (last_reg),
      .gnt  (pick)
   );

   assign win_pwrite = pick[M_AUX] ? m1_pwrite : m0_pwrite;
   assign win_paddr  = pick[M_AUX] ? m1_paddr  : m0_paddr;
   assign win_pdata  = pick[M_AUX] ? m1_pdata  : m0_pdata;
   assign win_pstb   = pick[M_AUX] ? m1_pstb   : m0_pstb;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] cnt_reg;

   assign timeout = (state_reg == ST_ACCESS) && (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (!rts_n) begin
         cnt_reg <= '0;
      end else if (state_reg == ST_SETUP) begin
         cnt_reg <= '0;
      end else if (state_reg == ST_ACCESS && !s_pready && !timeout) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign timeout    = 1'b0;
   assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

   // Once the watchdog fires it owns the response, so a late s_pready cannot leak data.
   assign done     = s_pready | timeout;
   assign complete = rts_n && (state_reg == ST_ACCESS) && done;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
         assign rsp_ready[gi] = complete & gnt_reg[gi];
         assign rsp_err[gi]   = rsp_ready[gi] & (timeout | s_perr);
         assign rsp_data[gi]  = (rsp_ready[gi] && !timeout) ? s_prdata : '0;
      end
   endgenerate

   assign m0_pready = rsp_ready[M_CPU];
   assign m0_perr   = rsp_err[M_CPU];
   assign m0_prdata = rsp_data[M_CPU];
   assign m1_pready = rsp_ready[M_AUX];
   assign m1_perr   = rsp_err[M_AUX];
   assign m1_prdata = rsp_data[M_AUX];

   always_ff @(posedge clk) begin
      if (!rts_n) begin
         state_reg   <= ST_IDLE;
         gnt_reg     <= '0;
         last_reg    <= 1'b1;
         psel_reg    <= 1'b0;
         penable_reg <= 1'b0;
         pwrite_reg  <= 1'b0;
         paddr_reg   <= '0;
         pdata_reg   <= '0;
         pstb_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (|pick) begin
                  gnt_reg    <= pick;
                  pwrite_reg <= win_pwrite;
                  paddr_reg  <= win_paddr;
                  pdata_reg  <= win_pdata;
                  pstb_reg   <= win_pwrite ? win_pstb : '1;
                  psel_reg   <= 1'b1;
                  state_reg  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_reg <= 1'b1;
               state_reg   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (done) begin
                  last_reg    <= gnt_reg[M_AUX];
                  gnt_reg     <= '0;
                  psel_reg    <= 1'b0;
                  penable_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_psel    = psel_reg;
   assign s_penable = penable_reg;
   assign s_pwrite  = pwrite_reg;
   assign s_paddr   = paddr_reg;
   assign s_pdata   = pdata_reg;
   assign s_pstb    = pstb_reg;
   assign gnt       = gnt_reg;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed protocol cases plus random traffic against a transaction-level model.
module tb_apb_arbiter;

   logic        clk = 1'b0;
   logic        rts_n;
   logic        psel [2];
   logic        penable [2];
   logic        pwrite [2];
   logic [31:0] paddr [2];
   logic [31:0] pdata [2];
   logic [3:0]  pstb [2];
   logic [31:0] o_prdata [2];
   logic        o_pready [2];
   logic        o_perr [2];
   logic        s_psel, s_penable, s_pwrite;
   logic [31:0] s_paddr, s_pdata, s_prdata;
   logic [3:0]  s_pstb;
   logic        s_pready, s_perr;
   logic [1:0]  gnt;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   always #5 clk = ~clk;

   apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rts_n(rts_n),
      .m0_psel(psel[0]), .m0_penable(penable[0]), .m0_pwrite(pwrite[0]),
      .m0_paddr(paddr[0]), .m0_pdata(pdata[0]), .m0_pstb(pstb[0]),
      .m0_prdata(o_prdata[0]), .m0_pready(o_pready[0]), .m0_perr(o_perr[0]),
      .m1_psel(psel[1]), .m1_penable(penable[1]), .m1_pwrite(pwrite[1]),
      .m1_paddr(paddr[1]), .m1_pdata(pdata[1]), .m1_pstb(pstb[1]),
      .m1_prdata(o_prdata[1]), .m1_pready(o_pready[1]), .m1_perr(o_perr[1]),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pdata(s_pdata), .s_pstb(s_pstb),
      .s_prdata(s_prdata), .s_pready(s_pready), .s_perr(s_perr),
      .gnt(gnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = '0; pdata[i] = '0; pstb[i] = '0;
      end
      s_prdata = '0; s_pready = 1'b0; s_perr = 1'b0;
   endtask

   task automatic do_reset(input bit check_state);
      rts_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      if (check_state) begin
         check("rst_gnt", gnt, 2'b00);
         check("rst_psel", s_psel, 0);
         check("rst_penable", s_penable, 0);
         check("rst_pwrite", s_pwrite, 0);
         check("rst_paddr", s_paddr, 0);
         check("rst_pdata", s_pdata, 0);
         check("rst_pstb", s_pstb, 0);
         check("rst_rdy0", o_pready[0], 0);
         check("rst_rdy1", o_pready[1], 0);
         check("rst_err0", o_perr[0], 0);
      end
      rts_n = 1'b1;
   endtask

   // m0 read; slave inserts two ACCESS wait cycles before answering.
   task automatic m0_read(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = addr; pstb[0] = 4'h3;
      @(negedge clk);
      check("lat_n1_psel", s_psel, 1);
      check("lat_n1_penable", s_penable, 0);
      check("lat_n1_gnt", gnt, 2'b01);
      check("rd_paddr", s_paddr, addr);
      check("rd_pstb_ones", s_pstb, 4'hF);
      penable[0] = 1'b1;
      #1 check("lat_n1_rdy0", o_pready[0], 0);
      for (int k = 2; k < 4; k++) begin
         @(negedge clk);
         check("lat_access_pen", s_penable, 1);
         #1 check("lat_wait_rdy0", o_pready[0], 0);
         check("lat_wait_rdy1", o_pready[1], 0);
      end
      @(negedge clk);
      s_pready = 1'b1; s_prdata = data;
      #1 check("lat_n4_rdy0", o_pready[0], 1);
      check("lat_n4_data0", o_prdata[0], data);
      check("lat_n4_rdy1", o_pready[1], 0);
      check("lat_n4_data1", o_prdata[1], 0);
      $display("txn %0d directed m0 read addr=%h data=%h", txn_no++, addr, o_prdata[0]);
      @(negedge clk);
      psel[0] = 1'b0; penable[0] = 1'b0; s_pready = 1'b0;
      check("rd_done_psel", s_psel, 0);
      check("rd_done_gnt", gnt, 2'b00);
      #1 check("rd_done_rdy0", o_pready[0], 0);
   endtask

   task automatic m1_write_capture();
      @(negedge clk);
      psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h4; pdata[1] = 32'h55; pstb[1] = 4'b0001;
      @(negedge clk);
      check("wr_gnt", gnt, 2'b10);
      @(negedge clk);
      paddr[1] = 32'h8; pdata[1] = 32'hAA;
      #1 check("wr_paddr_held", s_paddr, 32'h4);
      check("wr_pdata_held", s_pdata, 32'h55);
      check("wr_pstb", s_pstb, 4'b0001);
      check("wr_pwrite", s_pwrite, 1);
      @(negedge clk);
      s_pready = 1'b1; s_perr = 1'b1;
      #1 check("wr_rdy1", o_pready[1], 1);
      check("wr_err1", o_perr[1], 1);
      check("wr_rdy0", o_pready[0], 0);
      $display("txn %0d directed m1 write addr=%h err=%0d", txn_no++, s_paddr, o_perr[1]);
      @(negedge clk);
      psel[1] = 1'b0;
      #1 check("wr_err_one_cycle", o_perr[1], 0);
      check("wr_no_rdy_idle", o_pready[1], 0);
      s_pready = 1'b0; s_perr = 1'b0;
   endtask

   task automatic reset_mid_access();
      @(negedge clk);
      psel[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h20; pdata[0] = 32'h1234; pstb[0] = 4'hC;
      @(negedge clk);
      @(negedge clk);
      check("mid_in_access", s_penable, 1);
      rts_n = 1'b0; s_pready = 1'b1;
      #1 check("mid_no_rdy", o_pready[0], 0);
      @(negedge clk);
      psel[0] = 1'b0; s_pready = 1'b0;
      check("mid_psel", s_psel, 0);
      check("mid_penable", s_penable, 0);
      check("mid_gnt", gnt, 2'b00);
      #1 check("mid_rdy_after", o_pready[0], 0);
      rts_n = 1'b1;
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic timeout_case();
      @(negedge clk);
      psel[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h40;
      s_prdata = 32'hCAFE0000;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 check("to_wait_rdy", o_pready[0], 0);
      end
      @(negedge clk);
      #1 check("to_rdy", o_pready[0], 1);
      check("to_err", o_perr[0], 1);
      check("to_data", o_prdata[0], 0);
      $display("txn %0d directed m0 timeout", txn_no++);
      @(negedge clk);
      psel[0] = 1'b0; s_pready = 1'b1;
      check("to_psel_drop", s_psel, 0);
      #1 check("to_late_rdy", o_pready[0], 0);
      s_pready = 1'b0;
   endtask
`endif

   int grant_order [$];

   // Random traffic; requires the DUT to be freshly reset (idle, m0 wins first tie).
   task automatic run_random(input int n_done, input int max_gap, input int max_wait, input bit fair);
      bit          act [2];
      bit          fin [2];
      int          gap [2];
      int          phase, owner, last_own, wait_left, done, cyc;
      logic [31:0] c_addr, c_data;
      logic [3:0]  c_stb;
      logic        c_wr;
      logic [1:0]  exp_gnt;
      bit          rdy_exp;
      phase = 0; owner = 0; last_own = 1; wait_left = 0; done = 0; cyc = 0;
      c_addr = '0; c_data = '0; c_stb = '0; c_wr = 1'b0;
      grant_order.delete();
      for (int i = 0; i < 2; i++) begin act[i] = 1'b0; fin[i] = 1'b0; gap[i] = 0; end
      while (done < n_done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (fin[i]) begin
               act[i] = 1'b0; fin[i] = 1'b0;
               gap[i] = $urandom_range(max_gap, 0);
            end
            if (!act[i]) begin
               if (gap[i] == 0) begin
                  act[i]    = 1'b1;
                  pwrite[i] = 1'($urandom_range(1, 0));
                  paddr[i]  = $urandom & 32'h0000FFFC;
                  pdata[i]  = $urandom;
                  pstb[i]   = 4'($urandom_range(15, 0));
               end else begin
                  gap[i]--;
               end
            end
            psel[i]    = act[i];
            penable[i] = 1'($urandom_range(1, 0));
         end
         if (phase == 1) wait_left = $urandom_range(max_wait, 0);
         if (phase == 2) begin
            s_pready = (wait_left == 0);
            if (wait_left > 0) wait_left--;
         end else begin
            s_pready = 1'($urandom_range(1, 0));
         end
         s_prdata = $urandom;
         s_perr   = ($urandom_range(3, 0) == 0);
         #1;
         exp_gnt = (phase == 0) ? 2'b00 : (owner == 1 ? 2'b10 : 2'b01);
         check("r_psel", s_psel, phase != 0);
         check("r_penable", s_penable, phase == 2);
         check("r_gnt", gnt, exp_gnt);
         if (phase != 0) begin
            check("r_paddr", s_paddr, c_addr);
            check("r_pwrite", s_pwrite, c_wr);
            check("r_pdata", s_pdata, c_data);
            check("r_pstb", s_pstb, c_wr ? c_stb : 4'hF);
         end
         for (int i = 0; i < 2; i++) begin
            rdy_exp = (phase == 2) && (owner == i) && s_pready;
            check("r_pready", o_pready[i], rdy_exp);
            if (rdy_exp) begin
               check("r_prdata", o_prdata[i], s_prdata);
               check("r_perr", o_perr[i], s_perr);
               fin[i] = 1'b1;
               done++;
               grant_order.push_back(i);
               $display("txn %0d m%0d %s addr=%h wdata=%h rdata=%h err=%0d",
                        txn_no++, i, c_wr ? "wr" : "rd", c_addr, c_data, o_prdata[i], o_perr[i]);
            end else if (phase == 0 || owner != i) begin
               check("r_prdata_zero", o_prdata[i], 0);
            end
         end
         case (phase)
            0: if (psel[0] || psel[1]) begin
                  owner  = (psel[0] && psel[1]) ? 1 - last_own : (psel[1] ? 1 : 0);
                  c_wr   = pwrite[owner];
                  c_addr = paddr[owner];
                  c_data = pdata[owner];
                  c_stb  = pstb[owner];
                  phase  = 1;
               end
            1: phase = 2;
            default: if (s_pready) begin
                  phase = 0;
                  last_own = owner;
               end
         endcase
      end
      check("r_budget", done >= n_done, 1);
      if (fair) begin
         for (int k = 0; k < 6; k++) check("rr_order", grant_order[k], k % 2);
      end
   endtask

   initial begin
      do_reset(1'b1);
      m0_read(32'h1000, 32'hDEADBEEF);
      m1_write_capture();
      reset_mid_access();
      m0_read(32'h2000, 32'h0BADF00D);
`ifdef ARB_TIMEOUT_EN
      timeout_case();
`endif
      do_reset(1'b0);
      run_random(8, 0, 2, 1'b1);
      do_reset(1'b0);
      run_random(60, 3, 3, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
